// File: rtl/mem_stream_reader.sv
// Avalon-MM read master: fetches a run of words from a fixed one-cycle-latency
// memory and streams them out through a small FIFO with a last-word marker.
module mem_stream_reader #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     length,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_clken,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic [1:0]          state_dbg
);

  // Stream handshake: a word moves on any edge where out_valid & out_ready;
  // out_data/out_last are held while out_valid & !out_ready.

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                               state_q, state_d;
  logic [ADDR_W-1:0]                    base_q;
  logic [LEN_W-1:0]                     len_q;
  logic [LEN_W-1:0]                     issued_q;
  logic [LEN_W-1:0]                     captured_q;
  logic                                 inflight_q;
  logic                                 done_q;
  logic [FIFO_DEPTH-1:0][DATA_W-1:0]    fifo_data_q;
  logic [FIFO_DEPTH-1:0]                fifo_last_q;
  logic [PTR_W-1:0]                     wr_ptr_q;
  logic [PTR_W-1:0]                     rd_ptr_q;
  logic [CNT_W-1:0]                     count_q;

  logic             accept;
  logic             issue;
  logic             push;
  logic             pop;
  logic             head_last;
  logic [CNT_W:0]   occupancy;

  // Occupancy counts the word still in the memory pipeline so a push can
  // never find the FIFO full.
  assign occupancy = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
  assign accept    = (state_q == IDLE) && start;
  assign issue     = (state_q == FETCH) && (issued_q < len_q)
                     && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
  assign push      = inflight_q;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign head_last = fifo_last_q[rd_ptr_q];

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign mem_address    = issue ? (base_q + issued_q[ADDR_W-1:0]) : '0;
  assign mem_chipselect = issue;
  assign mem_clken      = issue;
  assign mem_write      = 1'b0;
  assign mem_byteenable = '1;
  assign out_data       = out_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign out_last       = out_valid && head_last;
  assign state_dbg      = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && (length != '0)) state_d = FETCH;
      FETCH:   if (issue && (issued_q == len_q - LEN_W'(1))) state_d = DRAIN;
      DRAIN:   if (pop && head_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      captured_q  <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      fifo_data_q <= '0;
      fifo_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      done_q     <= (accept && (length == '0))
                    || ((state_q == DRAIN) && pop && head_last);
      inflight_q <= issue;
      if (accept) begin
        base_q     <= base_addr;
        len_q      <= length;
        issued_q   <= '0;
        captured_q <= '0;
      end else if (issue) begin
        issued_q <= issued_q + LEN_W'(1);
      end
      if (push) begin
        fifo_data_q[wr_ptr_q] <= mem_readdata;
        fifo_last_q[wr_ptr_q] <= (captured_q == len_q - LEN_W'(1));
        wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
        captured_q            <= captured_q + LEN_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader: memory model, address/data scoreboard,
// stall-stability and occupancy monitors, and a summary report.
module tb_mem_stream_reader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [8:0]  base_addr;
  logic [9:0]  length;
  logic        busy;
  logic        done;
  logic [8:0]  mem_address;
  logic        mem_chipselect;
  logic        mem_clken;
  logic        mem_write;
  logic [1:0]  mem_byteenable;
  logic [15:0] mem_readdata;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [1:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  logic [16:0] exp_q[$];
  logic [8:0]  exp_addr_q[$];
  int          issued_total  = 0;
  int          popped_total  = 0;
  int          cyc           = 0;
  int          last_xfer_cyc = -10;
  logic        stall_prev    = 1'b0;
  logic [15:0] prev_data     = '0;
  logic        prev_last     = 1'b0;

  mem_stream_reader dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .length         (length),
    .busy           (busy),
    .done           (done),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_clken      (mem_clken),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_readdata   (mem_readdata),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .state_dbg      (state_dbg)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: word at address a holds 16'hA000 | a, one-cycle latency.
  initial mem_readdata = '0;
  always @(posedge clk)
    if (mem_clken && mem_chipselect) mem_readdata <= 16'hA000 | {7'd0, mem_address};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: issued addresses, delivered words, stall stability, occupancy bound.
  always @(negedge clk) begin
    if (reset) begin
      issued_total <= 0;
      popped_total <= 0;
      stall_prev   <= 1'b0;
    end else begin
      if (mem_chipselect) begin
        if (exp_addr_q.size() == 0) check("unexpected_issue", 1, 0);
        else check("mem_address", {23'd0, mem_address}, {23'd0, exp_addr_q.pop_front()});
        check("clken_with_cs", {31'd0, mem_clken}, 1);
        check("occupancy_le_4", {31'd0, (issued_total + 1 - popped_total) <= 4}, 1);
        issued_total <= issued_total + 1;
      end
      if (stall_prev && out_valid) begin
        check("stall_data_stable", {16'd0, out_data}, {16'd0, prev_data});
        check("stall_last_stable", {31'd0, out_last}, {31'd0, prev_last});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", 1, 0);
        else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          check("out_data", {16'd0, out_data}, {16'd0, e[15:0]});
          check("out_last", {31'd0, out_last}, {31'd0, e[16]});
        end
        if (out_last) last_xfer_cyc <= cyc;
        popped_total <= popped_total + 1;
      end
      stall_prev <= out_valid && !out_ready;
      prev_data  <= out_data;
      prev_last  <= out_last;
    end
  end

  // Driver tasks
  task automatic start_xfer(input logic [8:0] b, input logic [9:0] l);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic expect_run(input logic [8:0] b, input int l);
    for (int i = 0; i < l; i++) begin
      logic [8:0] a;
      a = b + 9'(i);
      exp_addr_q.push_back(a);
      exp_q.push_back({(i == l - 1), 16'hA000 | {7'd0, a}});
    end
  endtask

  task automatic wait_done(input string tag, input int max_cyc, input bit toggle);
    bit got;
    int done_cyc;
    got = 1'b0;
    done_cyc = 0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(posedge clk); #1;
      if (toggle) out_ready = ~out_ready;
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        done_cyc = cyc;
      end
    end
    check({tag, "_done_seen"}, {31'd0, got}, 1);
    if (got) begin
      check({tag, "_done_after_last"}, done_cyc, last_xfer_cyc + 1);
      check({tag, "_busy_low_at_done"}, {31'd0, busy}, 0);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, {31'd0, done}, 0);
    end
    out_ready = 1'b1;
    check({tag, "_all_words"}, exp_q.size(), 0);
    check({tag, "_all_addrs"}, exp_addr_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_valid"}, {31'd0, out_valid}, 0);
    check({tag, "_last"}, {31'd0, out_last}, 0);
    check({tag, "_data"}, {16'd0, out_data}, 0);
    check({tag, "_addr"}, {23'd0, mem_address}, 0);
    check({tag, "_cs"}, {31'd0, mem_chipselect}, 0);
    check({tag, "_clken"}, {31'd0, mem_clken}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base_cnt;
    bool_dummy: begin end
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    check("rst_write", {31'd0, mem_write}, 0);
    check("rst_byteenable", {30'd0, mem_byteenable}, 3);
    reset = 1'b0;

    // Basic run with latency checks
    exp_addr_q.push_back(9'h010); exp_addr_q.push_back(9'h011);
    exp_addr_q.push_back(9'h012); exp_addr_q.push_back(9'h013);
    exp_q.push_back({1'b0, 16'hA010}); exp_q.push_back({1'b0, 16'hA011});
    exp_q.push_back({1'b0, 16'hA012}); exp_q.push_back({1'b1, 16'hA013});
    start_xfer(9'h010, 10'd4);
    @(negedge clk);
    check("t1_first_issue", {31'd0, mem_chipselect}, 1);
    check("t1_busy", {31'd0, busy}, 1);
    check("t1_valid_c0", {31'd0, out_valid}, 0);
    @(negedge clk);
    check("t1_valid_c1", {31'd0, out_valid}, 0);
    @(negedge clk);
    check("t1_valid_c2", {31'd0, out_valid}, 1);
    check("t1_first_word", {16'd0, out_data}, 32'h0000A010);
    wait_done("t1", 20, 1'b0);

    // Address wrap
    exp_addr_q.push_back(9'h1FE); exp_addr_q.push_back(9'h1FF);
    exp_addr_q.push_back(9'h000); exp_addr_q.push_back(9'h001);
    exp_q.push_back({1'b0, 16'hA1FE}); exp_q.push_back({1'b0, 16'hA1FF});
    exp_q.push_back({1'b0, 16'hA000}); exp_q.push_back({1'b1, 16'hA001});
    start_xfer(9'h1FE, 10'd4);
    wait_done("t2", 20, 1'b0);

    // Backpressure: stall 10 cycles then toggle ready
    out_ready = 1'b0;
    base_cnt = issued_total;
    expect_run(9'h040, 20);
    start_xfer(9'h040, 10'd20);
    repeat (10) @(negedge clk);
    #1;
    check("t3_issues_while_stalled", issued_total - base_cnt, 4);
    check("t3_valid_stalled", {31'd0, out_valid}, 1);
    check("t3_head_stalled", {16'd0, out_data}, 32'h0000A040);
    wait_done("t3", 200, 1'b1);

    // Zero length
    start_xfer(9'h055, 10'd0);
    @(negedge clk);
    check("t4_done", {31'd0, done}, 1);
    check("t4_busy", {31'd0, busy}, 0);
    check("t4_no_cs", {31'd0, mem_chipselect}, 0);
    check("t4_no_valid", {31'd0, out_valid}, 0);
    @(negedge clk);
    check("t4_done_pulse", {31'd0, done}, 0);
    check("t4_no_valid_after", {31'd0, out_valid}, 0);

    // Start while busy is ignored
    expect_run(9'h080, 8);
    start_xfer(9'h080, 10'd8);
    @(negedge clk);
    check("t5_busy_before_restart", {31'd0, busy}, 1);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 9'h100; length = 10'd8;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t5", 40, 1'b0);
    repeat (5) @(negedge clk);
    check("t5_idle_after", {31'd0, busy}, 0);

    // Asynchronous reset mid-transfer, then a fresh run
    expect_run(9'h0C0, 10);
    base_cnt = popped_total;
    start_xfer(9'h0C0, 10'd10);
    for (int i = 0; i < 30 && (popped_total - base_cnt) < 3; i++) begin
      @(negedge clk); #1;
    end
    check("t6_three_words", {31'd0, (popped_total - base_cnt) >= 3}, 1);
    check("t6_busy_before_reset", {31'd0, busy}, 1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("t6_async_rst");
    exp_q.delete();
    exp_addr_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    exp_addr_q.push_back(9'h020); exp_addr_q.push_back(9'h021);
    exp_q.push_back({1'b0, 16'hA020}); exp_q.push_back({1'b1, 16'hA021});
    start_xfer(9'h020, 10'd2);
    wait_done("t6", 20, 1'b0);
    repeat (4) @(negedge clk);
    check("t6_no_extra_valid", {31'd0, out_valid}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stream_reader.md
# mem_stream_reader

Avalon-MM read master that fetches a contiguous run of 16-bit words from a 512x16 single-port on-chip sprite/pattern memory and presents them as a valid/ready stream with a last-word marker. It is the reading end of the sprite memories in soc_system: the memory slaves hold the image data, and this block pulls it out for the display pipeline. It handles the memory's fixed one-cycle read latency, wraps addresses, and never drops a word under downstream backpressure.

## Interface
- ADDR_W, 9, memory word-address width (depth 2^ADDR_W = 512)
- DATA_W, 16, memory and stream data width
- FIFO_DEPTH, 4, output buffer depth in words (power of two, >= 2)
- clk  in  1  single clock domain for the memory and the stream
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  first word address, latched on accepted start
- length  in  ADDR_W+1  number of words to read (0..1023), latched on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the transfer completes
- mem_address  out  ADDR_W  word address to the memory slave
- mem_chipselect  out  1  high on issue cycles
- mem_clken  out  1  memory clock enable; high on issue cycles only
- mem_write  out  1  constant 0
- mem_byteenable  out  DATA_W/8  constant all ones
- mem_readdata  in  DATA_W  memory read data, valid one cycle after the issue cycle
- out_data  out  DATA_W  stream data (FIFO head)
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  downstream accept; transfer occurs when out_valid & out_ready
- out_last  out  1  marks the final word of the transfer; qualified by out_valid

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE: when start=1, latch base_addr and length and set busy.
  - If length=0, pulse done on the next cycle and stay in IDLE.
  - Otherwise go to FETCH.
- FETCH: issue one read per cycle when both hold:
  - issued < length
  - fifo_count + inflight < FIFO_DEPTH, where inflight is the 1-bit flag for the previous cycle's issue.
- On an issue: mem_address = base + issued (mod 2^ADDR_W, so 511 wraps to 0), chipselect=1, clken=1, issued++.
- On the non-issue cycles in FETCH, chipselect=0 and clken=0.
- After the final issue, go to DRAIN.
- Capture: in the cycle after an issue, mem_readdata is written into the FIFO. The stored tag bit is last = (capture index == length-1).
- DRAIN: no issues. When the out_last word transfers, pulse done, clear busy and return to IDLE.
- A FIFO push and pop in the same cycle keep the count unchanged. The space check above guarantees a push is never refused.
- start while busy is ignored.
- length > 512 re-reads wrapped addresses; the word count is exact.
- Reset at any point: state=IDLE, FIFO empty, counters=0, inflight=0. The in-flight memory datum is discarded.

## Timing
- Reset values: busy=0, done=0, out_valid=0, out_last=0, out_data=0, mem_address=0, mem_chipselect=0, mem_clken=0. mem_write=0 and mem_byteenable=all ones at all times.
- Let E0 be the edge that samples start.
  - First issue in the cycle after E0.
  - Memory registers the address at E1; data is captured at E2.
  - out_valid=1 after E2, so first-word latency is 2 cycles.
- With out_ready held high, the block sustains one word per cycle.
- done rises the cycle after the edge where the last word transfers. busy falls on the same edge.
- With out_ready low, issues stop once fifo_count + inflight = FIFO_DEPTH. Issues resume in the cycle after the first pop.
- out_data and out_last stay stable while out_valid & !out_ready.

## Test plan
- base=0x010, length=4, out_ready=1:
  - mem_address sequence 0x010..0x013 on consecutive cycles.
  - out words equal to mem[0x010..0x013], out_last on the 4th word.
  - done 1 cycle after that word transfers, 2-cycle first-word latency.
- base=0x1FE, length=4: addresses 0x1FE, 0x1FF, 0x000, 0x001; data in that order.
- length=20 with out_ready low for 10 cycles then toggling 1/0:
  - At most 4 words buffered, no issue while full.
  - All 20 words arrive in order with no loss or duplication; out_data is stable while stalled.
- length=0: done pulses 1 cycle after start, no mem_chipselect, out_valid stays 0.
- start re-asserted mid-transfer (length=8, new base=0x100): ignored; all 8 words come from the original base.
- reset asserted asynchronously 3 words into a length=10 transfer:
  - All outputs go to their reset values immediately.
  - A new start with base=0x020, length=2 then delivers exactly mem[0x020], mem[0x021].
